// File: rtl/gemv_pkg.sv
// Shared GEMV definitions: default engine geometry and the result-drain
// state encoding. Imported by the GEMV engine and by gemv_result_drain.
package gemv_pkg;

    localparam int GEMV_DATA_WIDTH = 8;
    localparam int GEMV_ROWS       = 128;
    localparam int GEMV_LANES      = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } drain_state_t;

endpackage

// File: rtl/gemv_result_drain.sv
// gemv_result_drain: captures the full GEMV result vector on done_in and
// streams it out as ROWS/LANES beats of LANES elements on a valid/ready port.
// A done_in that lands on the final-beat transfer chains the next vector with
// no idle cycle; any other done_in while busy is dropped and flagged.
// Optional macro GEMV_DRAIN_RELU_EN: negative elements are stored as zero at
// capture. Without it elements are stored bit-exact.
// ROWS must be a multiple of LANES.
module gemv_result_drain
    import gemv_pkg::*;
#(
    parameter int DATA_WIDTH = GEMV_DATA_WIDTH,
    parameter int ROWS       = GEMV_ROWS,
    parameter int LANES      = GEMV_LANES,
    localparam int NBEATS    = ROWS / LANES,
    localparam int BEAT_W    = (NBEATS > 1) ? $clog2(NBEATS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ROWS*DATA_WIDTH-1:0]  y_in,
    input  logic                        done_in,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [LANES*DATA_WIDTH-1:0] m_data,
    output logic                        m_last,
    output logic [BEAT_W-1:0]           m_index,
    output logic                        busy,
    input  logic                        ovr_clr,
    output logic                        overrun
);

    localparam int                BEAT_BITS = LANES * DATA_WIDTH;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

    // Buffer organised as one packed word per output beat; element i of the
    // flat y_in lands in beat i/LANES, lane i%LANES.
    typedef logic [NBEATS-1:0][BEAT_BITS-1:0] buffer_t;

    drain_state_t      state;
    buffer_t           buffer;
    logic [BEAT_W-1:0] beat;
    logic              valid_q;
    logic              busy_q;
    logic              overrun_q;

    logic              xfer;
    logic              final_xfer;
    logic              drop;

    function automatic buffer_t capture(input logic [ROWS*DATA_WIDTH-1:0] v);
        logic [ROWS*DATA_WIDTH-1:0] r;
        r = v;
`ifdef GEMV_DRAIN_RELU_EN
        for (int i = 0; i < ROWS; i++) begin
            if (v[i*DATA_WIDTH + DATA_WIDTH-1]) begin
                r[i*DATA_WIDTH +: DATA_WIDTH] = '0;
            end
        end
`endif
        return buffer_t'(r);
    endfunction

    assign xfer       = valid_q && m_ready;
    assign final_xfer = xfer && (beat == LAST_BEAT);
    // A done_in is only accepted from IDLE or on the final-beat transfer.
    assign drop       = (state == STREAM) && done_in && !final_xfer;

    // Drain FSM: capture, beat advance, and chained restart on final beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            buffer  <= '0;
            beat    <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (done_in) begin
                        buffer  <= capture(y_in);
                        beat    <= '0;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state   <= STREAM;
                    end
                end
                STREAM: begin
                    if (final_xfer) begin
                        beat <= '0;
                        if (done_in) begin
                            buffer <= capture(y_in);
                        end else begin
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            state   <= IDLE;
                        end
                    end else if (xfer) begin
                        beat <= beat + BEAT_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Sticky overrun flag; a new drop takes priority over a clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_q <= 1'b0;
        end else if (drop) begin
            overrun_q <= 1'b1;
        end else if (ovr_clr) begin
            overrun_q <= 1'b0;
        end
    end

    // Output view is a pure function of registered state, never of m_ready.
    always_comb begin
        m_valid = valid_q;
        busy    = busy_q;
        overrun = overrun_q;
        m_index = beat;
        m_data  = buffer[beat];
        m_last  = valid_q && (beat == LAST_BEAT);
    end

endmodule

// File: tb/tb_gemv_result_drain.sv
// Self-checking bench for gemv_result_drain with ROWS=8, LANES=2 (4 beats).
// Expected beats are queued when a vector is loaded and popped on transfers.
module tb_gemv_result_drain;

    localparam int DW = 8;
    localparam int RW = 8;
    localparam int LN = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [63:0]   y_in = '0;
    logic          done_in = 1'b0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [15:0]   m_data;
    logic          m_last;
    logic [1:0]    m_index;
    logic          busy;
    logic          ovr_clr = 1'b0;
    logic          overrun;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  idx;
        logic        last;
    } beat_t;

    beat_t sb[$];

    gemv_result_drain #(.DATA_WIDTH(DW), .ROWS(RW), .LANES(LN)) dut (
        .clk(clk), .rst(rst), .y_in(y_in), .done_in(done_in),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last), .m_index(m_index), .busy(busy),
        .ovr_clr(ovr_clr), .overrun(overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] seq(input int start);
        logic [63:0] v;
        for (int i = 0; i < 8; i++) v[i*8 +: 8] = 8'(start + i);
        return v;
    endfunction

    // Drive y_in and optionally queue the beats the drain should produce.
    task automatic load_vec(input logic [63:0] v, input bit push);
        logic [7:0] e0, e1;
        y_in = v;
        if (push) begin
            for (int b = 0; b < 4; b++) begin
                e0 = v[(2*b)*8 +: 8];
                e1 = v[(2*b+1)*8 +: 8];
`ifdef GEMV_DRAIN_RELU_EN
                if (e0[7]) e0 = 8'h00;
                if (e1[7]) e1 = 8'h00;
`endif
                sb.push_back('{data: {e1, e0}, idx: 2'(b), last: (b == 3)});
            end
        end
    endtask

    // One-cycle done_in pulse; returns just after the capturing edge.
    task automatic pulse_done();
        @(posedge clk); #1 done_in = 1'b1;
        @(posedge clk); #1 done_in = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({m_valid, m_last, m_index, m_data, busy, overrun} !== 22'd0) begin
            errors++;
            $display("FAIL reset_state: v=%0b l=%0b i=%0d d=%h b=%0b o=%0b required all 0",
                     m_valid, m_last, m_index, m_data, busy, overrun);
        end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: m_valid=%0b required 0", m_valid);
        end
    endtask

    task automatic test_stream();
        beat_t exp;
        m_ready = 1'b1;
        load_vec(seq(1), 1'b1);
        pulse_done();
        for (int c = 0; c < 20 && sb.size() > 0; c++) begin
            @(negedge clk);
            checks++;
            if (m_valid !== 1'b1) begin
                errors++;
                $display("FAIL stream_valid: cycle %0d m_valid=%0b required 1", c, m_valid);
            end else begin
                exp = sb.pop_front();
                if ({m_data, m_index, m_last} !== {exp.data, exp.idx, exp.last}) begin
                    errors++;
                    $display("FAIL stream_beat: got d=%h i=%0d l=%0b required d=%h i=%0d l=%0b",
                             m_data, m_index, m_last, exp.data, exp.idx, exp.last);
                end
            end
        end
        if (sb.size() > 0) begin
            checks++; errors++;
            $display("FAIL stream_timeout: %0d beats left required 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
        checks++;
        if ({busy, m_valid} !== 2'b00) begin
            errors++;
            $display("FAIL stream_end: busy=%0b m_valid=%0b required 0 0", busy, m_valid);
        end
    endtask

    task automatic test_stall();
        beat_t       exp;
        bit [3:0]    pat = 4'b1001;
        bit          prev_stall = 1'b0;
        logic [15:0] prev_data = '0;
        logic [1:0]  prev_idx = '0;
        int          transfers = 0;
        m_ready = 1'b0;
        load_vec(seq(1), 1'b1);
        pulse_done();
        for (int c = 0; c < 40 && sb.size() > 0; c++) begin
            m_ready = pat[c % 4];
            @(negedge clk);
            if (prev_stall) begin
                checks++;
                if ({m_data, m_index} !== {prev_data, prev_idx}) begin
                    errors++;
                    $display("FAIL stall_hold: d=%h i=%0d required d=%h i=%0d",
                             m_data, m_index, prev_data, prev_idx);
                end
            end
            if (m_valid && m_ready) begin
                exp = sb.pop_front();
                transfers++;
                checks++;
                if ({m_data, m_index, m_last} !== {exp.data, exp.idx, exp.last}) begin
                    errors++;
                    $display("FAIL stall_beat: got d=%h i=%0d l=%0b required d=%h i=%0d l=%0b",
                             m_data, m_index, m_last, exp.data, exp.idx, exp.last);
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_idx   = m_index;
            @(posedge clk); #1;
        end
        m_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (transfers !== 4 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_count: transfers=%0d m_valid=%0b required 4 0", transfers, m_valid);
        end
        sb.delete();
    endtask

    task automatic test_overrun();
        beat_t exp;
        m_ready = 1'b0;
        load_vec(seq(1), 1'b1);
        pulse_done();
        m_ready = 1'b1;
        @(negedge clk);
        exp = sb.pop_front();
        checks++;
        if ({m_valid, m_data, m_index} !== {1'b1, exp.data, exp.idx}) begin
            errors++;
            $display("FAIL ovr_beat0: v=%0b d=%h i=%0d required 1 %h %0d", m_valid, m_data, m_index, exp.data, exp.idx);
        end
        @(posedge clk); #1 m_ready = 1'b0;
        load_vec(seq(9), 1'b0);
        done_in = 1'b1;
        @(posedge clk); #1 done_in = 1'b0;
        @(negedge clk);
        checks++;
        if ({overrun, m_index, m_data} !== {1'b1, 2'd1, sb[0].data}) begin
            errors++;
            $display("FAIL ovr_drop: o=%0b i=%0d d=%h required 1 1 %h", overrun, m_index, m_data, sb[0].data);
        end
        @(posedge clk); #1 ovr_clr = 1'b1;
        @(posedge clk); #1 ovr_clr = 1'b0;
        @(negedge clk);
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL ovr_clear: overrun=%0b required 0", overrun);
        end
        @(posedge clk); #1 ovr_clr = 1'b1; done_in = 1'b1;
        @(posedge clk); #1 ovr_clr = 1'b0; done_in = 1'b0;
        @(negedge clk);
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_set_wins: overrun=%0b required 1", overrun);
        end
        @(posedge clk); #1 ovr_clr = 1'b1;
        @(posedge clk); #1 ovr_clr = 1'b0; m_ready = 1'b1;
        for (int c = 0; c < 20 && sb.size() > 0; c++) begin
            @(negedge clk);
            if (m_valid) begin
                exp = sb.pop_front();
                checks++;
                if ({m_data, m_index, m_last} !== {exp.data, exp.idx, exp.last}) begin
                    errors++;
                    $display("FAIL ovr_rest: got d=%h i=%0d l=%0b required d=%h i=%0d l=%0b",
                             m_data, m_index, m_last, exp.data, exp.idx, exp.last);
                end
            end
        end
        if (sb.size() > 0) begin
            checks++; errors++;
            $display("FAIL ovr_timeout: %0d beats left required 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        beat_t exp;
        bit    chained = 1'b0;
        m_ready = 1'b1;
        load_vec(seq(1), 1'b1);
        pulse_done();
        for (int c = 0; c < 30 && sb.size() > 0; c++) begin
            @(negedge clk);
            checks++;
            if (m_valid !== 1'b1) begin
                errors++;
                $display("FAIL b2b_gap: cycle %0d m_valid=%0b required 1", c, m_valid);
            end else begin
                exp = sb.pop_front();
                if ({m_data, m_index, m_last} !== {exp.data, exp.idx, exp.last}) begin
                    errors++;
                    $display("FAIL b2b_beat: got d=%h i=%0d l=%0b required d=%h i=%0d l=%0b",
                             m_data, m_index, m_last, exp.data, exp.idx, exp.last);
                end
                if (exp.last && !chained) begin
                    chained = 1'b1;
                    load_vec(seq(9), 1'b1);
                    done_in = 1'b1;
                    @(posedge clk); #1 done_in = 1'b0;
                end
            end
        end
        if (sb.size() > 0) begin
            checks++; errors++;
            $display("FAIL b2b_timeout: %0d beats left required 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
        checks++;
        if ({m_valid, overrun} !== 2'b00) begin
            errors++;
            $display("FAIL b2b_end: m_valid=%0b overrun=%0b required 0 0", m_valid, overrun);
        end
    endtask

    task automatic test_reset_mid();
        beat_t exp;
        bit    seen = 1'b0;
        m_ready = 1'b1;
        load_vec(seq(1), 1'b1);
        pulse_done();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            exp = sb.pop_front();
            checks++;
            if ({m_valid, m_data, m_index} !== {1'b1, exp.data, exp.idx}) begin
                errors++;
                $display("FAIL rmid_beat: v=%0b d=%h i=%0d required 1 %h %0d", m_valid, m_data, m_index, exp.data, exp.idx);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({m_valid, busy, m_index, m_data} !== 20'd0) begin
            errors++;
            $display("FAIL rmid_async: v=%0b b=%0b i=%0d d=%h required all 0", m_valid, busy, m_index, m_data);
        end
        sb.delete();
        @(posedge clk); #1 rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (m_valid) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL rmid_silent: beat seen after reset, required none");
        end
    endtask

    task automatic test_relu();
        beat_t       exp;
        logic [63:0] v;
        logic [15:0] want [2];
        v = {8'h7E, 8'h06, 8'h81, 8'h03, 8'h7F, 8'h80, 8'h05, 8'hFF};
`ifdef GEMV_DRAIN_RELU_EN
        want[0] = {8'h05, 8'h00};
        want[1] = {8'h7F, 8'h00};
`else
        want[0] = {8'h05, 8'hFF};
        want[1] = {8'h7F, 8'h80};
`endif
        m_ready = 1'b1;
        load_vec(v, 1'b1);
        pulse_done();
        for (int c = 0; c < 20 && sb.size() > 0; c++) begin
            @(negedge clk);
            if (m_valid) begin
                if (exp.idx < 2 && sb.size() > 2) begin
                    checks++;
                    if (m_data !== want[4 - sb.size()]) begin
                        errors++;
                        $display("FAIL relu_const: d=%h required %h", m_data, want[4 - sb.size()]);
                    end
                end
                exp = sb.pop_front();
                checks++;
                if ({m_data, m_index, m_last} !== {exp.data, exp.idx, exp.last}) begin
                    errors++;
                    $display("FAIL relu_beat: got d=%h i=%0d l=%0b required d=%h i=%0d l=%0b",
                             m_data, m_index, m_last, exp.data, exp.idx, exp.last);
                end
            end
        end
        if (sb.size() > 0) begin
            checks++; errors++;
            $display("FAIL relu_timeout: %0d beats left required 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        test_relu();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gemv_result_drain.md
GEMV_RESULT_DRAIN -- requirements
Module: gemv_result_drain

Interface
REQ-001 Parameters: DATA_WIDTH, 8, element width in bits.
REQ-002 Parameters: ROWS, 128, result vector length.
REQ-003 Parameters: LANES, 4, elements per output beat; ROWS SHALL be a multiple of LANES.
REQ-004 Derived: NBEATS = ROWS/LANES; BEAT_W = max(1, $clog2(NBEATS)).
REQ-005 clk  input  1  clock, all state updated on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 y_in  input  ROWS x DATA_WIDTH  result vector from the GEMV engine, valid in the done_in cycle.
REQ-008 done_in  input  1  single-cycle pulse from the GEMV engine marking y_in valid.
REQ-009 m_valid  output  1  output beat valid.
REQ-010 m_ready  input  1  downstream accepts the beat.
REQ-011 m_data  output  LANES*DATA_WIDTH  lane k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-012 m_last  output  1  high with the final beat of a vector.
REQ-013 m_index  output  BEAT_W  index of the current beat.
REQ-014 busy  output  1  high while a captured vector is not yet fully drained.
REQ-015 ovr_clr  input  1  clears the overrun flag.
REQ-016 overrun  output  1  sticky flag: done_in arrived while busy and was dropped.

Function
REQ-017 States SHALL be IDLE and STREAM.
REQ-018 IDLE + done_in: the block SHALL copy y_in into the internal buffer, clear the beat counter and enter STREAM on the same edge.
REQ-019 STREAM SHALL drive m_valid=1 and busy=1; the beat is transferred when m_valid && m_ready.
REQ-020 Lane k of m_data SHALL equal buffer[m_index*LANES+k].
REQ-021 m_last SHALL equal (m_index == NBEATS-1) while m_valid is high, else 0.
REQ-022 m_data, m_last and m_index SHALL stay stable while m_valid=1 and m_ready=0.
REQ-023 A transfer on a non-final beat SHALL increment m_index by 1.
REQ-024 A transfer on the final beat without done_in SHALL return to IDLE, with m_valid=0 on the next cycle.
REQ-025 If a transfer on the final beat coincides with done_in, the block SHALL capture the new y_in and restart at beat 0 in STREAM with no idle cycle.
REQ-026 done_in in STREAM outside the REQ-025 case SHALL be dropped, with the buffer unchanged and overrun set to 1.
REQ-027 overrun SHALL clear on ovr_clr; if a set and ovr_clr occur in the same cycle, the set wins.
REQ-028 First-beat latency: m_valid SHALL be high in the cycle after done_in.
REQ-029 Minimum drain time: NBEATS cycles when m_ready is held at 1.
REQ-030 The output path SHALL have no combinational dependence on m_ready.

Reset
REQ-031 rst SHALL force state=IDLE, m_valid=0, m_last=0, m_index=0, m_data=0, busy=0 and overrun=0, and clear the buffer to 0, immediately and without waiting for clk.
REQ-032 rst asserted mid-vector SHALL abandon the vector; after release no beat is emitted until the next done_in.

Configuration
REQ-033 Macro GEMV_DRAIN_RELU_EN defined: at capture, each element with its MSB set (negative as signed) SHALL be stored as 0, and other elements stored unchanged.
REQ-034 Macro GEMV_DRAIN_RELU_EN undefined: elements SHALL be stored bit-exact.

Structure
REQ-035 Package gemv_pkg SHALL hold the drain_state_t enum (IDLE, STREAM) and the default DATA_WIDTH/ROWS/LANES constants shared with the GEMV engine.
REQ-036 The block SHALL be a single module with the lane selection inline; no sub-module.

Verification (bench parameters: DATA_WIDTH=8, ROWS=8, LANES=2, NBEATS=4)
REQ-037 Capture y_in={1..8}, pulse done_in, hold m_ready=1 -> 4 consecutive beats {1,2},{3,4},{5,6},{7,8}, m_last only on the 4th, busy low one cycle after the final beat.
REQ-038 Same vector, m_ready toggled 1,0,0,1,... -> m_data/m_index held during stalls; the beat order is unchanged and exactly 4 transfers occur.
REQ-039 Second done_in during beat 1 -> vector unchanged, overrun=1; ovr_clr pulse -> overrun=0; ovr_clr together with another drop -> overrun stays 1.
REQ-040 done_in in the same cycle as the final-beat transfer with y_in={9..16} -> next cycle m_valid=1, m_index=0, m_data={9,10}.
REQ-041 rst asserted during beat 2 -> m_valid=0 at once; no beats after release until a new done_in.
REQ-042 With GEMV_DRAIN_RELU_EN defined, y_in={8'hFF,5,8'h80,127,...} -> first beats {0,5},{0,127}; with the macro undefined -> {FF,05},{80,7F}.
